// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer for the LC-3b multicycle datapath: owns the PC,
// runs the memory read handshake and offers each word to the IR via valid/ready.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [15:0] ir_word,
  output logic [15:0] ir_pc,
  output logic [15:0] pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] ir_word_q, ir_word_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic [15:0] target;
  logic [15:0] pc_inc;

  assign target = {redirect_pc[15:1], 1'b0};
  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    pend_pc_d = pend_pc_q;
    ir_word_d = ir_word_q;
    ir_pc_d   = ir_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = target;
      end
      REQ: begin
        if (mem_resp) begin
          if (kill_q || redirect) begin
            // Read was overtaken by a control-flow change: drop the data.
            pc_d    = redirect ? target : pend_pc_q;
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ir_word_d = mem_rdata;
            ir_pc_d   = pc_inc;
            pc_d      = pc_inc;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable while the read is outstanding.
          kill_d    = 1'b1;
          pend_pc_d = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = IDLE;
        end else if (ir_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      pend_pc_q <= 16'h0000;
      ir_word_q <= 16'h0000;
      ir_pc_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      pend_pc_q <= pend_pc_d;
      ir_word_q <= ir_word_d;
      ir_pc_q   <= ir_pc_d;
    end
  end

  assign mem_read    = (state_q == REQ);
  assign ir_valid    = (state_q == HOLD);
  assign mem_address = pc_q;
  assign pc          = pc_q;
  assign ir_word     = ir_word_q;
  assign ir_pc       = ir_pc_q;

endmodule
